// File: rtl/div_reconstruct_mul.sv
// Round-trip checker for the 8-bit divider: rebuilds N = Q*D + R with a
// sequential shift-add multiplier whose accumulator starts at R, and flags
// tuples that no legal divide could have produced (D==0 or R>=D).
module div_reconstruct_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din_Q,
  input  logic [WIDTH-1:0]   din_D,
  input  logic [WIDTH-1:0]   din_R,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [2*WIDTH-1:0] dout_N,
  output logic               dout_ovf,
  output logic               dout_err,
  output logic               dout_valid,
  input  logic               dout_ready
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        cnt_q;
  logic                 err_q;
  logic                 din_ready_q;
  logic                 dout_valid_q;
  logic [2*WIDTH-1:0]   dout_n_q;
  logic                 dout_ovf_q;
  logic                 dout_err_q;

  // One shift-add step: add the shifted divisor when the current quotient bit is set.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  // Control FSM plus datapath; all outputs are registered so din_* never reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_n_q     <= '0;
      dout_ovf_q   <= 1'b0;
      dout_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (din_valid && din_ready_q) begin
            acc_q       <= {{WIDTH{1'b0}}, din_R};
            mcand_q     <= {{WIDTH{1'b0}}, din_D};
            mplier_q    <= din_Q;
            cnt_q       <= CW'(WIDTH);
            err_q       <= (din_D == '0) || (din_R >= din_D);
            din_ready_q <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          // Fixed WIDTH iterations; no early exit so latency is data-independent.
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            // Last step: publish the final sum directly so dout_valid lands WIDTH edges after accept.
            dout_n_q     <= acc_d;
            dout_ovf_q   <= |acc_d[2*WIDTH-1:WIDTH];
            dout_err_q   <= err_q;
            dout_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          // Result and flags hold after the handshake until the next result overwrites them.
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          din_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout_N     = dout_n_q;
  assign dout_ovf   = dout_ovf_q;
  assign dout_err   = dout_err_q;

endmodule

// File: tb/tb_div_reconstruct_mul.sv
// Bench for div_reconstruct_mul: directed vector table, backpressure and
// mid-run reset sequences, then random divider round-trips and random tuples
// checked against plain-arithmetic expectations.
module tb_div_reconstruct_mul;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   din_Q, din_D, din_R;
  logic           din_valid;
  logic           din_ready;
  logic [2*W-1:0] dout_N;
  logic           dout_ovf, dout_err, dout_valid;
  logic           dout_ready;

  int total = 0;
  int bad   = 0;

  div_reconstruct_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .din_Q(din_Q), .din_D(din_D), .din_R(din_R),
    .din_valid(din_valid), .din_ready(din_ready),
    .dout_N(dout_N), .dout_ovf(dout_ovf), .dout_err(dout_err),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  q, d, r;
    logic [15:0] n;
    logic        ovf, err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one tuple from IDLE and consume its result; checks latency and outputs.
  task automatic do_tuple(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r,
                          input int exp_n, input int exp_ovf, input int exp_err,
                          input bit early_rdy, input string nm);
    int lat;
    chk({nm, ".din_ready"}, int'(din_ready), 1);
    din_Q = q; din_D = d; din_R = r; din_valid = 1'b1;
    dout_ready = early_rdy;
    step();
    // Scramble inputs after accept; they must not matter.
    din_valid = 1'b0;
    din_Q = ~q; din_D = ~d; din_R = ~r;
    lat = 0;
    while (!dout_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({nm, ".latency"}, lat, W);
    chk({nm, ".N"}, int'(dout_N), exp_n);
    chk({nm, ".ovf"}, int'(dout_ovf), exp_ovf);
    chk({nm, ".err"}, int'(dout_err), exp_err);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    chk({nm, ".valid_drop"}, int'(dout_valid), 0);
    chk({nm, ".N_hold"}, int'(dout_N), exp_n);
  endtask

  vec_t vecs[6];

  initial begin
    int n, d, q, r, e;
    rst_n = 1'b0;
    din_Q = '0; din_D = '0; din_R = '0; din_valid = 1'b0; dout_ready = 1'b0;
    #12;
    chk("reset.din_ready", int'(din_ready), 1);
    chk("reset.valid", int'(dout_valid), 0);
    chk("reset.N", int'(dout_N), 0);
    chk("reset.ovf", int'(dout_ovf), 0);
    chk("reset.err", int'(dout_err), 0);
    rst_n = 1'b1;
    step();

    vecs[0] = '{8'd5,   8'd2,   8'd0,   16'd10,    1'b0, 1'b0};
    vecs[1] = '{8'd3,   8'd3,   8'd1,   16'd10,    1'b0, 1'b0};
    vecs[2] = '{8'd0,   8'd7,   8'd6,   16'd6,     1'b0, 1'b0};
    vecs[3] = '{8'd255, 8'd255, 8'd254, 16'd65279, 1'b1, 1'b0};
    vecs[4] = '{8'd1,   8'd4,   8'd4,   16'd8,     1'b0, 1'b1};
    vecs[5] = '{8'd9,   8'd0,   8'd3,   16'd3,     1'b0, 1'b1};
    for (int i = 0; i < 6; i++)
      do_tuple(vecs[i].q, vecs[i].d, vecs[i].r, int'(vecs[i].n),
               int'(vecs[i].ovf), int'(vecs[i].err), 1'b0, $sformatf("vec%0d", i));

    // Backpressure: result held, new tuples ignored while DONE stalls.
    din_Q = 8'd6; din_D = 8'd7; din_R = 8'd2; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < W; i++) step();
    chk("bp.valid_rise", int'(dout_valid), 1);
    for (int i = 0; i < 5; i++) begin
      din_valid = i[0] ? 1'b0 : 1'b1;
      din_Q = 8'(50 + i); din_D = 8'(60 + i); din_R = 8'(1 + i);
      step();
      chk("bp.valid_hold", int'(dout_valid), 1);
      chk("bp.N_hold", int'(dout_N), 44);
      chk("bp.din_ready", int'(din_ready), 0);
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    chk("bp.release_valid", int'(dout_valid), 0);
    chk("bp.release_ready", int'(din_ready), 1);
    chk("bp.N_after", int'(dout_N), 44);
    do_tuple(8'd2, 8'd3, 8'd1, 7, 0, 0, 1'b0, "bp_next");

    // Reset in the middle of RUN.
    din_Q = 8'd200; din_D = 8'd100; din_R = 8'd5; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst.N", int'(dout_N), 0);
    chk("rst.valid", int'(dout_valid), 0);
    chk("rst.din_ready", int'(din_ready), 1);
    #3 rst_n = 1'b1;
    e = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dout_valid) e++;
    end
    chk("rst.no_valid", e, 0);
    do_tuple(8'd12, 8'd10, 8'd7, 127, 0, 0, 1'b0, "rst_next");

    // Random divider round-trips: N -> (Q,R) by division, then back.
    for (int i = 0; i < 200; i++) begin
      n = int'($urandom_range(0, 255));
      d = int'($urandom_range(1, 255));
      q = n / d;
      r = n % d;
      do_tuple(8'(q), 8'(d), 8'(r), n, 0, 0, i[0], "rt");
    end

    // Random arbitrary tuples, including illegal ones.
    for (int i = 0; i < 60; i++) begin
      q = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, 255));
      r = int'($urandom_range(0, 255));
      if (i % 10 == 0) d = 0;
      n = q * d + r;
      do_tuple(8'(q), 8'(d), 8'(r), n, (n > 255) ? 1 : 0,
               (d == 0 || r >= d) ? 1 : 0, 1'b0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
